// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 sensor-side model: accepts a trigger pulse and returns an echo whose
// width encodes a programmed distance (last_cm * CYC_PER_CM, or a timeout width).
module ultrasonic_echo_responder #(
    parameter int TRIG_MIN_CYC = 500,
    parameter int BURST_CYC    = 10000,
    parameter int CYC_PER_CM   = 2900,
    parameter int MAX_CM       = 400,
    parameter int TIMEOUT_CYC  = 1900000,
    parameter int HOLDOFF_CYC  = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       done,
    output logic       trig_err,
    output logic [8:0] last_cm
);

    localparam int M1      = (TIMEOUT_CYC > HOLDOFF_CYC) ? TIMEOUT_CYC : HOLDOFF_CYC;
    localparam int M2      = (BURST_CYC > TRIG_MIN_CYC) ? BURST_CYC : TRIG_MIN_CYC;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [CW-1:0] TRIG_MIN   = CW'(TRIG_MIN_CYC);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYC);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] HO_LAST    = CW'(HOLDOFF_CYC - 1);
    localparam logic [SW-1:0] SUB_LAST   = SW'(CYC_PER_CM - 1);
    localparam logic [8:0]    MAX_D      = 9'(MAX_CM);

    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] sub_cnt, sub_nxt;
    logic [8:0]    cm_cnt, cm_nxt;
    logic [8:0]    last_nxt;
    logic          echo_nxt, done_nxt, err_nxt;

    logic       trig_m, trig_s, trig_q;
    logic [1:0] primed;
    logic       need_low;
    logic       rise, fall, in_range;

    // need_low blocks a trigger that was already high when reset released:
    // the synchronizer must first show a genuine low before any rise counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_m   <= 1'b0;
            trig_s   <= 1'b0;
            trig_q   <= 1'b0;
            primed   <= 2'b00;
            need_low <= 1'b1;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
            trig_q <= trig_s;
            primed <= {primed[0], 1'b1};
            if (primed[1] && !trig_s)
                need_low <= 1'b0;
        end
    end

    assign rise     = trig_s & ~trig_q & ~need_low;
    assign fall     = ~trig_s & trig_q;
    assign in_range = (last_cm != 9'd0) && (last_cm <= MAX_D);
    assign busy     = (state == BURST) || (state == ECHO) || (state == HOLDOFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sub_cnt  <= '0;
            cm_cnt   <= '0;
            echo     <= 1'b0;
            done     <= 1'b0;
            trig_err <= 1'b0;
            last_cm  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sub_cnt  <= sub_nxt;
            cm_cnt   <= cm_nxt;
            echo     <= echo_nxt;
            done     <= done_nxt;
            trig_err <= err_nxt;
            last_cm  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sub_nxt   = sub_cnt;
        cm_nxt    = cm_cnt;
        echo_nxt  = echo;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        last_nxt  = last_cm;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = TRIG_HI;
                    cnt_nxt   = CW'(1);
                end
            end
            TRIG_HI: begin
                if (fall) begin
                    cnt_nxt = '0;
                    if (cnt >= TRIG_MIN) begin
                        last_nxt  = distance_cm;
                        state_nxt = BURST;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (trig_s && cnt < TRIG_MIN) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BURST: begin
                err_nxt = rise;
                if (cnt == BURST_LAST) begin
                    state_nxt = ECHO;
                    echo_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    sub_nxt   = '0;
                    cm_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ECHO: begin
                err_nxt = rise;
                // (cm_cnt, sub_cnt) together count elapsed echo cycles in cm units
                if (in_range) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_nxt = '0;
                        if (cm_cnt == last_cm - 9'd1) begin
                            state_nxt = HOLDOFF;
                            echo_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                            cm_nxt    = '0;
                            cnt_nxt   = '0;
                        end else begin
                            cm_nxt = cm_cnt + 9'd1;
                        end
                    end else begin
                        sub_nxt = sub_cnt + 1'b1;
                    end
                end else begin
                    if (cnt == TO_LAST) begin
                        state_nxt = HOLDOFF;
                        echo_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                err_nxt = rise;
                if (cnt == HO_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                echo_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Bench for ultrasonic_echo_responder: vector table, directed busy/reset
// sequences and random measurements against an arithmetic echo-width model.
module tb_ultrasonic_echo_responder;

    localparam int T_MIN = 5;
    localparam int BURST = 10;
    localparam int CPC   = 4;
    localparam int MAXC  = 400;
    localparam int TO    = 50;
    localparam int HO    = 20;
    // trigger sampled low at edge L+1, synchronized at L+2, fall acted on at L+3
    localparam int RISE_LAT = 4 + BURST;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic [8:0] distance_cm;
    logic       echo, busy, done, trig_err;
    logic [8:0] last_cm;

    ultrasonic_echo_responder #(
        .TRIG_MIN_CYC(T_MIN), .BURST_CYC(BURST), .CYC_PER_CM(CPC),
        .MAX_CM(MAXC), .TIMEOUT_CYC(TO), .HOLDOFF_CYC(HO)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .distance_cm(distance_cm),
        .echo(echo), .busy(busy), .done(done), .trig_err(trig_err), .last_cm(last_cm)
    );

    always #5 clk = ~clk;

    int   edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // observer: records echo pulses and counts pulses on the status outputs
    logic echo_p = 1'b0;
    int   cur_w = 0, rise_cnt = 0, fall_cnt = 0, last_rise = 0, last_width = 0;
    int   done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    logic last_fall_done = 1'b0;
    always @(negedge clk) begin
        if (echo && !echo_p) begin rise_cnt++; last_rise = edge_n; cur_w = 0; end
        if (echo) cur_w++;
        if (!echo && echo_p) begin fall_cnt++; last_width = cur_w; last_fall_done = done; end
        if (done) done_cnt++;
        if (trig_err) err_cnt++;
        if (busy) busy_cnt++;
        echo_p = echo;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int model_width(input int d, input int w);
        if (w < T_MIN) return 0;
        if (d >= 1 && d <= MAXC) return d * CPC;
        return TO;
    endfunction

    task automatic trig_pulse(input int w, output int L);
        trigger = 1'b1;
        repeat (w) tick();
        trigger = 1'b0;
        L = edge_n;
    endtask

    task automatic wait_rise(input int r0);
        int t = 0;
        while (rise_cnt == r0 && t < 500) begin tick(); t++; end
    endtask

    task automatic wait_fall(input int f0);
        int t = 0;
        while (fall_cnt == f0 && t < 5000) begin tick(); t++; end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin tick(); t++; end
    endtask

    task automatic run_meas(input string tag, input int d, input int w, input int exp_w);
        int f0, e0, d0, b0, r0, L;
        distance_cm = 9'(d);
        f0 = fall_cnt; e0 = err_cnt; d0 = done_cnt; b0 = busy_cnt; r0 = rise_cnt;
        trig_pulse(w, L);
        if (exp_w > 0) begin
            wait_fall(f0);
            check({tag, "_echo_seen"}, fall_cnt - f0, 1);
            check({tag, "_rise_lat"}, last_rise - L, RISE_LAT);
            check({tag, "_width"}, last_width, exp_w);
            check({tag, "_done_at_fall"}, int'(last_fall_done), 1);
            check({tag, "_last_cm"}, int'(last_cm), d);
            wait_idle();
            check({tag, "_idle"}, int'(busy), 0);
            check({tag, "_done_cnt"}, done_cnt - d0, 1);
            check({tag, "_err_cnt"}, err_cnt - e0, 0);
        end else begin
            repeat (30) tick();
            check({tag, "_err_cnt"}, err_cnt - e0, 1);
            check({tag, "_no_echo"}, rise_cnt - r0, 0);
            check({tag, "_no_busy"}, busy_cnt - b0, 0);
        end
        repeat (3) tick();
    endtask

    typedef struct {
        int d;
        int w;
        int exp_w;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int L, Lx, f0, e0, d0, r0, b0;
        vecs[0] = '{d: 3,   w: 8,  exp_w: 12};
        vecs[1] = '{d: 0,   w: 6,  exp_w: 50};
        vecs[2] = '{d: 450, w: 6,  exp_w: 50};
        vecs[3] = '{d: 3,   w: 3,  exp_w: 0};
        vecs[4] = '{d: 1,   w: 5,  exp_w: 4};
        vecs[5] = '{d: 8,   w: 4,  exp_w: 0};
        vecs[6] = '{d: 400, w: 5,  exp_w: 1600};
        vecs[7] = '{d: 401, w: 5,  exp_w: 50};
        vecs[8] = '{d: 511, w: 9,  exp_w: 50};
        vecs[9] = '{d: 7,   w: 12, exp_w: 28};

        reset = 1'b1; trigger = 1'b0; distance_cm = '0;
        repeat (3) tick();
        check("rst_echo", int'(echo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_trig_err", int'(trig_err), 0);
        check("rst_last_cm", int'(last_cm), 0);
        reset = 1'b0;
        repeat (5) tick();

        foreach (vecs[i]) run_meas($sformatf("vec%0d", i), vecs[i].d, vecs[i].w, vecs[i].exp_w);

        // triggers during ECHO and HOLDOFF are rejected without disturbing the echo
        distance_cm = 9'd10;
        f0 = fall_cnt; e0 = err_cnt; d0 = done_cnt; r0 = rise_cnt;
        trig_pulse(6, L);
        wait_rise(r0);
        repeat (5) tick();
        trig_pulse(3, Lx);
        wait_fall(f0);
        check("busy_echo_seen", fall_cnt - f0, 1);
        tick();
        trig_pulse(2, Lx);
        wait_idle();
        check("busy_rise_lat", last_rise - L, RISE_LAT);
        check("busy_width", last_width, 40);
        check("busy_err_cnt", err_cnt - e0, 2);
        check("busy_done_cnt", done_cnt - d0, 1);
        repeat (5) tick();

        // distance changes after acceptance are ignored
        distance_cm = 9'd5;
        f0 = fall_cnt;
        trig_pulse(6, L);
        repeat (4) tick();
        distance_cm = 9'd9;
        wait_fall(f0);
        check("dchg_echo_seen", fall_cnt - f0, 1);
        check("dchg_width", last_width, 20);
        check("dchg_last_cm", int'(last_cm), 5);
        wait_idle();
        repeat (3) tick();

        // reset mid-ECHO drops echo at once
        distance_cm = 9'd10;
        r0 = rise_cnt;
        trig_pulse(6, L);
        wait_rise(r0);
        repeat (5) tick();
        check("mid_echo_high", int'(echo), 1);
        reset = 1'b1;
        #1;
        check("rst_mid_echo", int'(echo), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_last_cm", int'(last_cm), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        run_meas("post_reset", 7, 6, 28);

        // trigger held high across reset release is not a new trigger
        trigger = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        b0 = busy_cnt; e0 = err_cnt; r0 = rise_cnt;
        reset = 1'b0;
        repeat (20) tick();
        check("held_no_busy", busy_cnt - b0, 0);
        check("held_no_err", err_cnt - e0, 0);
        check("held_no_echo", rise_cnt - r0, 0);
        trigger = 1'b0;
        repeat (5) tick();
        run_meas("post_hold", 6, 6, 24);

        for (int i = 0; i < 15; i++) begin
            int d, w;
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 20));
            w = $urandom_range(1, 10);
            run_meas($sformatf("rnd%0d_d%0d_w%0d", i, d, w), d, w, model_width(d, w));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
